// File: rtl/serial_word_tx_if.sv
// CPU-side write port and UART status of serial_word_tx.
// master = CPU driving writes, slave = transmitter.
interface serial_word_tx_if;
  logic        SerialWrite;
  logic [15:0] SerialData;
  logic        TxD;
  logic        Busy;
  logic        Full;
  logic        Overflow;

  modport master (
    output SerialWrite, SerialData,
    input  TxD, Busy, Full, Overflow
  );

  modport slave (
    input  SerialWrite, SerialData,
    output TxD, Busy, Full, Overflow
  );
endinterface

// File: rtl/serial_word_tx.sv
// 16-bit word FIFO feeding an 8N1 UART transmitter.
// Each word goes out as two frames, low byte first, with no gap between them.
module serial_word_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  serial_word_tx_if.slave   bus
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("CLKS_PER_BIT must be at least 2");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2 and at least 2");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        r_state;
  state_t        w_state_next;

  logic [CW-1:0] r_bit_cnt;
  logic [2:0]    r_bit_idx;
  logic [15:0]   r_shift;
  logic          r_hi;

  logic [15:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [AW:0]   w_count_next;

  logic          r_txd;
  logic          r_busy;
  logic          r_full;
  logic          r_ovf;

  logic          w_tick;
  logic          w_have;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic          w_txd_next;

  assign w_have = (r_count != '0);
  assign w_tick = (r_bit_cnt == CW'(CLKS_PER_BIT - 1));

  // A pop on the same edge frees a slot, so a write into a full FIFO still lands.
  assign w_push = bus.SerialWrite && ((r_count != (AW+1)'(FIFO_DEPTH)) || w_pop);
  assign w_drop = bus.SerialWrite && !w_push;

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + (AW+1)'(1);
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - (AW+1)'(1);
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_next;
      r_full  <= (w_count_next == (AW+1)'(FIFO_DEPTH));
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.SerialData;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:  if (w_have) w_state_next = START;
      START: if (w_tick) w_state_next = DATA;
      DATA:  if (w_tick && (r_bit_idx == 3'd7)) w_state_next = STOP;
      STOP: begin
        if (w_tick) begin
          if (!r_hi || w_have) w_state_next = START;
          else                 w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // TxD is registered, so the line value is derived from the state being entered.
  always_comb begin
    w_pop      = w_have && ((r_state == IDLE) || ((r_state == STOP) && w_tick && r_hi));
    w_txd_next = 1'b1;
    case (w_state_next)
      START:   w_txd_next = 1'b0;
      DATA:    w_txd_next = ((r_state == DATA) && w_tick) ? r_shift[1] : r_shift[0];
      default: w_txd_next = 1'b1;
    endcase
  end

  // The shifter drops one bit per DATA bit, leaving the high byte in [7:0] after the low byte.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_bit_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_hi      <= 1'b0;
      r_txd     <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      if ((r_state == IDLE) || w_tick) r_bit_cnt <= '0;
      else                             r_bit_cnt <= r_bit_cnt + CW'(1);

      if (r_state != DATA)  r_bit_idx <= '0;
      else if (w_tick)      r_bit_idx <= r_bit_idx + 3'd1;

      if (w_pop)                          r_shift <= r_mem[r_rd_ptr];
      else if ((r_state == DATA) && w_tick) r_shift <= {1'b0, r_shift[15:1]};

      if (w_pop)                                     r_hi <= 1'b0;
      else if ((r_state == STOP) && w_tick && !r_hi) r_hi <= 1'b1;

      r_txd  <= w_txd_next;
      r_busy <= (w_count_next != '0) || (w_state_next != IDLE);
    end
  end

  assign bus.TxD      = r_txd;
  assign bus.Busy     = r_busy;
  assign bus.Full     = r_full;
  assign bus.Overflow = r_ovf;

endmodule

// File: tb/tb_serial_word_tx.sv
// Bench for serial_word_tx: directed writes push expected bytes into a queue,
// a UART monitor decodes TxD frames and pops/compares.
module tb_serial_word_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  serial_word_tx_if bus ();

  serial_word_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .Clock (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [7:0]  exp_q[$];
  int          starts[$];
  int          cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic expect_word(input logic [15:0] w);
    exp_q.push_back(w[7:0]);
    exp_q.push_back(w[15:8]);
  endtask

  task automatic wait_idle(input int limit, input string name);
    int n = 0;
    while (bus.Busy !== 1'b0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(name, (n < limit), 1);
  endtask

  // UART monitor: captures every cycle of a frame so bit widths are checked exactly.
  logic [9:0] fb;
  int         fpos  = 0;
  bit         infr  = 0;
  bit         glitch = 0;
  always begin
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      infr = 0;
    end else begin
      if (!infr && bus.TxD === 1'b0) begin
        infr   = 1;
        fpos   = 0;
        glitch = 0;
        starts.push_back(cyc);
      end
      if (infr) begin
        if (fpos % CPB == 0) fb[fpos / CPB] = bus.TxD;
        else if (bus.TxD !== fb[fpos / CPB]) glitch = 1;
        fpos++;
        if (fpos == 10 * CPB) begin
          infr = 0;
          chk("frame_bit_width", glitch, 0);
          chk("frame_stop_bit", fb[9], 1);
          chk("frame_expected_pending", (exp_q.size() != 0), 1);
          if (exp_q.size() != 0) chk("frame_byte", fb[8:1], exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  logic [15:0] w[6];
  int idle_bad;

  initial begin
    bus.SerialWrite = 1'b0;
    bus.SerialData  = '0;
    repeat (3) @(negedge clk);
    chk("reset_txd", bus.TxD, 1);
    chk("reset_busy", bus.Busy, 0);
    chk("reset_full", bus.Full, 0);
    chk("reset_overflow", bus.Overflow, 0);
    rst_n = 1'b1;

    // idle line
    idle_bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (bus.TxD !== 1'b1 || bus.Busy !== 1'b0) idle_bad++;
    end
    chk("idle_line", idle_bad, 0);

    // single word 0xA53C: bytes 3C then A5
    starts.delete();
    expect_word(16'hA53C);
    @(negedge clk); bus.SerialWrite = 1'b1; bus.SerialData = 16'hA53C;
    @(negedge clk); bus.SerialWrite = 1'b0;
    chk("single_txd_edge_k", bus.TxD, 1);
    chk("single_busy_edge_k", bus.Busy, 1);
    @(negedge clk);
    chk("single_txd_edge_k1", bus.TxD, 0);
    repeat (79) @(negedge clk);
    chk("single_busy_last_cycle", bus.Busy, 1);
    chk("single_stop_last_cycle", bus.TxD, 1);
    @(negedge clk);
    chk("single_busy_low", bus.Busy, 0);
    chk("single_frame_count", starts.size(), 2);
    if (starts.size() == 2) chk("single_frame_gap", starts[1] - starts[0], 40);
    chk("single_drained", exp_q.size(), 0);

    // back-to-back 0x0001, 0x0002: bytes 01,00,02,00 over 160 cycles
    starts.delete();
    expect_word(16'h0001);
    expect_word(16'h0002);
    @(negedge clk); bus.SerialWrite = 1'b1; bus.SerialData = 16'h0001;
    @(negedge clk); bus.SerialData = 16'h0002;
    @(negedge clk); bus.SerialWrite = 1'b0;
    repeat (159) @(negedge clk);
    chk("b2b_busy_last_cycle", bus.Busy, 1);
    @(negedge clk);
    chk("b2b_busy_low", bus.Busy, 0);
    chk("b2b_frame_count", starts.size(), 4);
    for (int i = 1; i < starts.size(); i++) chk("b2b_frame_gap", starts[i] - starts[i-1], 40);
    chk("b2b_drained", exp_q.size(), 0);

    // overflow: 6 writes back-to-back, 6th dropped
    for (int i = 0; i < 6; i++) w[i] = 16'hB0A0 + 16'(i) * 16'h0101;
    for (int i = 0; i < 5; i++) expect_word(w[i]);
    @(negedge clk); bus.SerialWrite = 1'b1; bus.SerialData = w[0];
    for (int i = 1; i < 6; i++) begin
      @(negedge clk);
      if (i == 5) begin
        chk("ovf_full_after_5", bus.Full, 1);
        chk("ovf_not_yet", bus.Overflow, 0);
      end
      bus.SerialData = w[i];
    end
    @(negedge clk); bus.SerialWrite = 1'b0;
    chk("ovf_set", bus.Overflow, 1);
    chk("ovf_full_kept", bus.Full, 1);
    wait_idle(1000, "ovf_drain_timeout");
    chk("ovf_sticky", bus.Overflow, 1);
    chk("ovf_drained", exp_q.size(), 0);

    @(negedge clk); #2 rst_n = 1'b0;
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    chk("rst_clears_overflow", bus.Overflow, 0);

    // full FIFO with write on the STOP(HI) pop edge
    for (int i = 0; i < 6; i++) w[i] = 16'hD0C0 + 16'(i) * 16'h0101;
    for (int i = 0; i < 6; i++) expect_word(w[i]);
    @(negedge clk); bus.SerialWrite = 1'b1; bus.SerialData = w[0];
    for (int i = 1; i < 5; i++) begin
      @(negedge clk); bus.SerialData = w[i];
    end
    @(negedge clk); bus.SerialWrite = 1'b0;
    chk("simpop_full", bus.Full, 1);
    repeat (76) @(negedge clk);
    chk("simpop_full_before_pop", bus.Full, 1);
    bus.SerialWrite = 1'b1; bus.SerialData = w[5];
    @(negedge clk); bus.SerialWrite = 1'b0;
    chk("simpop_no_overflow", bus.Overflow, 0);
    chk("simpop_full_after", bus.Full, 1);
    wait_idle(2000, "simpop_drain_timeout");
    chk("simpop_drained", exp_q.size(), 0);

    // reset during DATA of the low byte
    @(negedge clk); bus.SerialWrite = 1'b1; bus.SerialData = 16'h1234;
    @(negedge clk); bus.SerialWrite = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_txd", bus.TxD, 1);
    chk("midrst_busy", bus.Busy, 0);
    chk("midrst_full", bus.Full, 0);
    @(negedge clk); @(negedge clk);
    chk("midrst_txd_held", bus.TxD, 1);
    expect_word(16'h00FF);
    rst_n = 1'b1; bus.SerialWrite = 1'b1; bus.SerialData = 16'h00FF;
    @(negedge clk); bus.SerialWrite = 1'b0;
    chk("postrst_txd_edge_k", bus.TxD, 1);
    chk("postrst_busy", bus.Busy, 1);
    @(negedge clk);
    chk("postrst_txd_edge_k1", bus.TxD, 0);
    wait_idle(200, "postrst_drain_timeout");
    repeat (50) @(negedge clk);
    chk("postrst_idle_txd", bus.TxD, 1);
    chk("postrst_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
